// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Boot-time instruction memory writer. Receives a byte stream
//                over valid/ready: a 4-byte big-endian length header followed
//                by the payload. Payload bytes are written to ascending byte
//                addresses from 0. The core is held in reset until a complete
//                image has been written.
//                Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//                (adds one trailing XOR checksum byte after the payload).
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_BYTES  = 8191
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HDR   = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CHK   = 3'd3;
`endif
    localparam logic [2:0] c_FLUSH = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;
    localparam logic [2:0] c_ERR   = 3'd6;

    // State entered once the payload (or an empty header) has been consumed.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_AFTER_PAYLOAD = c_CHK;
`else
    localparam logic [2:0] c_AFTER_PAYLOAD = c_FLUSH;
`endif

    localparam logic [31:0] c_MAX_LEN = 32'(MEM_BYTES);

    logic [2:0]            state_q,   state_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [31:0]           len_q,     len_d;
    logic [31:0]           cnt_q,     cnt_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [7:0]            wdata_q,   wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q,    csum_d;
`endif

    logic                  w_accept;
    logic [31:0]           w_hdr_len;
    logic [ADDR_WIDTH-1:0] w_cnt_ext;

    assign w_accept  = in_valid & in_ready;
    // Length as it will look once the current header byte is shifted in.
    assign w_hdr_len = {len_q[23:0], in_data};
    // The header check bounds the counter, so plain zero-extension is enough.
    assign w_cnt_ext = ADDR_WIDTH'(cnt_q);

    // Status outputs decoded purely from the current state.
    always_comb begin
        in_ready = (state_q == c_HDR) || (state_q == c_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        in_ready = in_ready || (state_q == c_CHK);
`endif
        busy     = in_ready || (state_q == c_FLUSH);
        done     = (state_q == c_DONE);
        error    = (state_q == c_ERR);
        cpu_hold = (state_q != c_DONE);
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next-state logic: header parsing, payload write generation, checksum.
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            c_IDLE, c_DONE, c_ERR: begin
                if (start) begin
                    state_d   = c_HDR;
                    hdr_cnt_d = 2'd0;
                    len_d     = 32'd0;
                    cnt_d     = 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d    = 8'd0;
`endif
                end
            end
            c_HDR: begin
                if (w_accept) begin
                    len_d     = w_hdr_len;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if (w_hdr_len > c_MAX_LEN) begin
                            state_d = c_ERR;
                        end else if (w_hdr_len == 32'd0) begin
                            state_d = c_AFTER_PAYLOAD;
                        end else begin
                            state_d = c_DATA;
                            cnt_d   = 32'd0;
                        end
                    end
                end
            end
            c_DATA: begin
                if (w_accept) begin
                    we_d    = 1'b1;
                    addr_d  = w_cnt_ext;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + 32'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    if (cnt_q == len_q - 32'd1) begin
                        state_d = c_AFTER_PAYLOAD;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            c_CHK: begin
                if (w_accept) begin
                    state_d = (in_data == csum_q) ? c_FLUSH : c_ERR;
                end
            end
`endif
            c_FLUSH: begin
                // Lets the final write land before the core is released.
                state_d = c_DONE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= c_IDLE;
            hdr_cnt_q <= 2'd0;
            len_q     <= 32'd0;
            cnt_q     <= 32'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader. Random and directed
//                images are streamed in; the expected memory image, write
//                order and status timing are derived from the stream itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW = 64;
    localparam int MB = 8191;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'd0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    program_loader #(
        .ADDR_WIDTH (AW),
        .MEM_BYTES  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;
    logic [AW+7:0] wq[$];

    // Observed write log; also flags any write while the core is released.
    always @(negedge clk) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            if (!cpu_hold) overlap++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance (plus a gap
    // cycle when requested, optionally pulsing start in that gap).
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse_start);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        if (gap) begin
            start = pulse_start;
            check("ready_in_stall", in_ready, 1);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic pulse_start_chk();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", in_ready, 1);
        check("start_done", done, 0);
        check("start_error", error, 0);
        check("start_hold", cpu_hold, 1);
    endtask

    task automatic run_load(input logic [7:0] pl[$], input bit stall, input bit bad_csum);
        logic [7:0]  s[$];
        logic [31:0] len;
        logic [7:0]  x;
        int          n;
        n   = pl.size();
        len = n;
        x   = 8'd0;
        foreach (pl[i]) x ^= pl[i];
        for (int i = 0; i < 4; i++) s.push_back(len[31-8*i -: 8]);
        foreach (pl[i]) s.push_back(pl[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        s.push_back(bad_csum ? (x ^ 8'h01) : x);
`endif
        wq.delete();
        pulse_start_chk();
        for (int i = 0; i < s.size(); i++)
            send_byte(s[i], stall && (i != s.size() - 1), stall && (i == 5));
        // first cycle after the final accepted byte
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("post_we", mem_we, 0);
        if (bad_csum) begin
            check("csum_err", error, 1);
            check("csum_err_hold", cpu_hold, 1);
            check("csum_err_busy", busy, 0);
            check("csum_err_done", done, 0);
        end else begin
            check("flush_busy", busy, 1);
            check("flush_done", done, 0);
            check("flush_hold", cpu_hold, 1);
        end
`else
        check("flush_we", mem_we, (n > 0));
        if (n > 0) begin
            check("flush_addr", mem_addr, n - 1);
            check("flush_data", mem_wdata, pl[n-1]);
        end
        check("flush_busy", busy, 1);
        check("flush_done", done, 0);
        check("flush_hold", cpu_hold, 1);
        check("flush_ready", in_ready, 0);
`endif
        @(negedge clk);
        if (!bad_csum) begin
            check("done", done, 1);
            check("done_hold", cpu_hold, 0);
            check("done_busy", busy, 0);
            check("done_error", error, 0);
            check("done_we", mem_we, 0);
        end else begin
            check("err_stays", error, 1);
        end
        check("write_count", wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check("write_addr", wq[i][AW+7:8], i);
            check("write_data", wq[i][7:0], pl[i]);
        end
    endtask

    task automatic hdr_error(input logic [31:0] len);
        wq.delete();
        pulse_start_chk();
        for (int i = 0; i < 4; i++) send_byte(len[31-8*i -: 8], 1'b0, 1'b0);
        check("herr_error", error, 1);
        check("herr_hold", cpu_hold, 1);
        check("herr_busy", busy, 0);
        check("herr_ready", in_ready, 0);
        check("herr_done", done, 0);
        @(negedge clk);
        check("herr_error2", error, 1);
        check("herr_no_writes", wq.size(), 0);
        pulse_start_chk();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void rand_payload(output logic [7:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    endfunction

    initial begin
        logic [7:0] pl[$];
        logic [7:0] fixed[$];
        fixed = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h01, 8'h13};

        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_load(fixed, 1'b0, 1'b0);
        run_load(fixed, 1'b1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            rand_payload(pl, $urandom_range(1, 40));
            run_load(pl, ($urandom_range(0, 1) == 1), 1'b0);
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        pl = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(pl, 1'b0, 1'b0);
        run_load(pl, 1'b0, 1'b1);
        rand_payload(pl, $urandom_range(1, 20));
        run_load(pl, 1'b1, 1'b1);
`endif

        hdr_error(32'd8192);
        hdr_error(32'hFFFF_FFFF);
        hdr_error(32'd8192 + $urandom_range(0, 100000));

        // Reset in the middle of a payload
        rand_payload(pl, 8);
        wq.delete();
        pulse_start_chk();
        for (int i = 0; i < 4; i++) send_byte(8'(i == 3 ? 8 : 0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(pl[i], 1'b0, 1'b0);
        check("mid_we", mem_we, 1);
        check("mid_addr", mem_addr, 2);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = pl[3];
        @(negedge clk);
        check("mrst_we", mem_we, 0);
        check("mrst_busy", busy, 0);
        check("mrst_hold", cpu_hold, 1);
        check("mrst_ready", in_ready, 0);
        check("mrst_done", done, 0);
        check("mrst_writes", wq.size(), 3);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        run_load(pl, 1'b0, 1'b0);

        // Empty image
        pl.delete();
        run_load(pl, 1'b0, 1'b0);

        // Largest legal image
        rand_payload(pl, MB);
        run_load(pl, 1'b0, 1'b0);

        check("no_write_when_released", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, parses a 4-byte big-endian length header, and writes the payload bytes into instruction memory at ascending byte addresses from 0. Bytes are stored in stream order, so each 32-bit instruction is sent MSB first: the byte at address `a` is `instruction[31:24]` and the byte at `a+3` is `instruction[7:0]`. Holds the core in reset until a complete image has been written, and sits between the host link (UART/JTAG bridge) and the memory's write port.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: width of `mem_addr`. Matches the fetch address width.
- `MEM_BYTES`, 8191: instruction memory capacity in bytes. This is the maximum legal payload length.

Ports:
- `clk`  in  1: the single clock; everything is on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: single-cycle pulse that begins a load.
- `in_valid`  in  1: stream byte valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader can accept a byte.
- `mem_we`  out  1: byte write strobe, one cycle per byte.
- `mem_addr`  out  ADDR_WIDTH: write byte address.
- `mem_wdata`  out  8: write byte.
- `busy`  out  1: load in progress.
- `done`  out  1: last load completed successfully.
- `error`  out  1: last load aborted.
- `cpu_hold`  out  1: holds the core in reset while high.

## Operation
- States: IDLE, HDR, DATA, CHK (only when checksum is compiled in), FLUSH, DONE, ERR.
- Reset values: state = IDLE; `in_ready`, `mem_we`, `busy`, `done`, `error` = 0; `mem_addr` = 0; `mem_wdata` = 0; `cpu_hold` = 1.
- A byte is accepted when `in_valid & in_ready`.
- `in_ready` = 1 exactly in HDR, DATA and CHK. It is decoded from the state only and never depends on `in_valid`.
- `busy` = 1 in HDR, DATA, CHK and FLUSH.
- `cpu_hold` = 0 only in DONE.
- IDLE, DONE, ERR:
  - `start` moves to HDR and clears the header counter, length, byte counter and running XOR.
  - `done` and `error` drop on that transition.
  - `start` in any other state is ignored.
- HDR:
  - Each accepted byte shifts into the 32-bit length, first byte into the MSB.
  - On the 4th byte: length > `MEM_BYTES` goes to ERR; length = 0 goes to CHK if enabled, otherwise FLUSH; any other length goes to DATA with the byte counter at 0.
- DATA:
  - An accepted byte is registered to `mem_wdata`, with `mem_addr` = byte counter and `mem_we` = 1 on the next cycle only.
  - The counter then increments and the byte is XORed into the running checksum.
  - The byte whose counter value equals length−1 goes to CHK if enabled, otherwise FLUSH.
- FLUSH: one cycle. The final `mem_we` pulse is visible here. Then DONE.
- DONE: `done` = 1 and the core is released. Memory contents persist.
- ERR: `error` = 1 and `cpu_hold` = 1. Bytes already written stay in memory and are not scrubbed.
- Address arithmetic: the byte counter is 32 bits, zero-extended to ADDR_WIDTH. It never exceeds `MEM_BYTES`−1 because of the header check, so there is no wrap.
- Reset mid-load: returns to IDLE with `cpu_hold` = 1. Any `mem_we` pending at that edge is dropped. The partial image is left in memory.
- `in_valid` low in HDR, DATA or CHK stalls in place with no timeout.

## Timing
- Byte accepted at edge k drives `mem_we`/`mem_addr`/`mem_wdata` during cycle k+1. Writes are one cycle late relative to acceptance.
- Throughput: one byte per cycle sustained.
- Final byte accepted at edge k:
  - without CHK: FLUSH in cycle k+1 (final `mem_we` = 1), DONE in cycle k+2 (`cpu_hold` falls).
  - with CHK: final `mem_we` in k+1 while in CHK. Checksum byte accepted at edge j moves to FLUSH in j+1, then DONE in j+2; a mismatch moves to ERR in j+1 instead.
- The core is never released in the same cycle as any memory write.
- Header error: 4th header byte at edge k gives ERR (`error` = 1) in cycle k+1. No `mem_we` is ever asserted.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - after the payload, one extra byte equal to the XOR of all payload bytes is expected (0x00 for an empty payload);
  - a match goes to FLUSH; a mismatch goes to ERR.
- Undefined: there is no CHK state, DATA or HDR go straight to FLUSH, and `error` is raised only by a length overflow.

## Test plan
- Header 00 00 00 08, payload 00 50 00 93 00 A0 01 13 at full rate → 8 `mem_we` pulses at addresses 0..7 with the bytes in order; `done` = 1 two cycles after the last byte; `cpu_hold` falls together with `done`.
- Same image with `in_valid` toggling every other cycle → identical writes and `in_ready` steady high; `done` asserts exactly two cycles after the final accepted byte.
- Header 00 00 20 00 (8192 > 8191) → `error` = 1 one cycle later, no `mem_we`, `cpu_hold` = 1; a new `start` clears `error` and moves to HDR.
- With `PROGRAM_LOADER_CHECKSUM_EN`, payload 12 34 56 78 then checksum 08 → DONE; a second run with checksum 09 → ERR, `cpu_hold` = 1.
- `rst_n` = 0 after 3 of 8 payload bytes → next cycle IDLE, `mem_we` = 0, `busy` = 0, `cpu_hold` = 1; a fresh full load then succeeds.
- Header 00 00 00 00 (checksum off) → FLUSH then DONE two cycles after the 4th header byte, with no writes.
